// File: rtl/spinner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spinner_pkg
// Description : Shared types, constants and helpers for the spinner bank.
// Revision    : 1.0 - initial release
// ============================================================================
package spinner_pkg;

    localparam int SPIN_PKT_W = 9;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } dir_t;

    function automatic int clamp_pos(input int sum, input int lo, input int hi);
        if (sum < lo) begin
            return lo;
        end
        if (sum > hi) begin
            return hi;
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spinner_chan.sv
`default_nettype none
// ============================================================================
// Module      : spinner_chan
// Description : One position accumulator merging button steps and analog
//               spinner packets. Build option: SPINNER_ACCEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spinner_chan
    import spinner_pkg::*;
#(
    parameter int OUT_W    = 8,
    parameter int STEP_MIN = 1,
    parameter int STEP_MAX = 12,
    parameter int STEP_INC = 1,
    parameter int SPIN_SHL = 0,
    parameter int CLAMP    = 0,
    parameter int POS_MIN  = 0,
    parameter int POS_MAX  = (1 << OUT_W) - 1,
    parameter int POS_INIT = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_sedge,
    input  logic                  i_plus,
    input  logic                  i_minus,
    input  logic [SPIN_PKT_W-1:0] i_spin,
    output logic [OUT_W-1:0]      o_pos,
    output logic                  o_moved,
    output logic                  o_pkt
);

    // Step register needs headroom for one increment before the ceiling test.
    localparam int c_STEP_W = $clog2(STEP_MAX + STEP_INC + 1);
    // Wide enough that no pos + step + shifted delta combination overflows.
    localparam int c_SUM_W  = ((OUT_W > 11) ? OUT_W : 11) + 3;
    localparam logic [c_STEP_W-1:0] c_STEP_MIN = c_STEP_W'(STEP_MIN);
    localparam logic [OUT_W-1:0]    c_POS_INIT = OUT_W'(POS_INIT);

    logic [OUT_W-1:0]           r_pos;
    logic                       r_moved;
    logic                       r_armed;
    logic                       r_tog_d;
    logic                       w_btn;
    logic                       w_pkt;
    logic [c_STEP_W-1:0]        w_step_use;
    logic signed [7:0]          w_raw;
    logic signed [c_SUM_W-1:0]  w_aext;
    logic signed [c_SUM_W-1:0]  w_step_ext;
    logic signed [c_SUM_W-1:0]  w_pos_ext;
    logic signed [c_SUM_W-1:0]  w_bdelta;
    logic signed [c_SUM_W-1:0]  w_adelta;
    logic signed [c_SUM_W-1:0]  w_sum;
    logic [OUT_W-1:0]           w_pos_next;

    assign w_btn = i_plus ^ i_minus;

`ifdef SPINNER_ACCEL_EN
    localparam logic [c_STEP_W-1:0] c_STEP_MAX = c_STEP_W'(STEP_MAX);

    dir_t                r_dir_last;
    dir_t                w_dir_next;
    logic [c_STEP_W-1:0] r_step;
    logic [c_STEP_W-1:0] w_step_next;
    logic [c_STEP_W-1:0] w_grow;

    // A reversal (or first press) restarts at the minimum step before growing.
    always_comb begin
        w_dir_next  = r_dir_last;
        w_step_next = r_step;
        w_step_use  = r_step;
        w_grow      = '0;
        if (i_sedge) begin
            if (w_btn) begin
                w_dir_next = i_plus ? UP : DN;
                if (w_dir_next != r_dir_last) begin
                    w_step_use = c_STEP_MIN;
                end
                w_grow      = w_step_use + c_STEP_W'(STEP_INC);
                w_step_next = (w_grow > c_STEP_MAX) ? c_STEP_MAX : w_grow;
            end else begin
                w_dir_next  = NONE;
                w_step_next = c_STEP_MIN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dir_last <= NONE;
            r_step     <= c_STEP_MIN;
        end else begin
            r_dir_last <= w_dir_next;
            r_step     <= w_step_next;
        end
    end
`else
    assign w_step_use = c_STEP_MIN;
`endif

    assign w_step_ext = $signed({{(c_SUM_W - c_STEP_W){1'b0}}, w_step_use});
    assign w_pos_ext  = $signed({{(c_SUM_W - OUT_W){1'b0}}, r_pos});

    always_comb begin
        w_bdelta = '0;
        if (i_sedge && w_btn) begin
            w_bdelta = i_plus ? w_step_ext : -w_step_ext;
        end
    end

    // The first cycle after reset only learns the toggle phase.
    assign w_pkt    = r_armed && (i_spin[SPIN_PKT_W-1] != r_tog_d);
    assign w_raw    = i_spin[7:0];
    assign w_aext   = w_raw;
    assign w_adelta = w_pkt ? (w_aext <<< SPIN_SHL) : '0;
    assign w_sum    = w_pos_ext + w_bdelta + w_adelta;

    always_comb begin
        w_pos_next = w_sum[OUT_W-1:0];
        if (CLAMP != 0) begin
            w_pos_next = OUT_W'(clamp_pos(int'(w_sum), POS_MIN, POS_MAX));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos   <= c_POS_INIT;
            r_moved <= 1'b0;
            r_armed <= 1'b0;
            r_tog_d <= 1'b0;
        end else begin
            r_pos   <= w_pos_next;
            r_moved <= (w_pos_next != r_pos);
            r_armed <= 1'b1;
            r_tog_d <= i_spin[SPIN_PKT_W-1];
        end
    end

    assign o_pos   = r_pos;
    assign o_moved = r_moved;
    assign o_pkt   = w_pkt;

endmodule
`default_nettype wire

// File: rtl/spinner_bank.sv
`default_nettype none
// ============================================================================
// Module      : spinner_bank
// Description : Parametrised bank of spinner/button position channels with
//               shared strobe edge detect and last-analog-channel tracking.
//               Build option: SPINNER_ACCEL_EN enables button acceleration.
// Revision    : 1.0 - initial release
// ============================================================================
module spinner_bank
    import spinner_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int OUT_W    = 8,
    parameter int STEP_MIN = 1,
    parameter int STEP_MAX = 12,
    parameter int STEP_INC = 1,
    parameter int SPIN_SHL = 0,
    parameter int CLAMP    = 0,
    parameter int POS_MIN  = 0,
    parameter int POS_MAX  = (1 << OUT_W) - 1,
    parameter int POS_INIT = 0,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           strobe,
    input  logic [CHANNELS-1:0]            plus,
    input  logic [CHANNELS-1:0]            minus,
    input  logic [SPIN_PKT_W*CHANNELS-1:0] spin_in,
    output logic [OUT_W*CHANNELS-1:0]      pos,
    output logic [CHANNELS-1:0]            moved,
    output logic [CH_W-1:0]                active_ch
);

    logic                r_strobe_d;
    logic                w_sedge;
    logic [CHANNELS-1:0] w_pkt;
    logic [CH_W-1:0]     r_active_ch;
    logic [CH_W-1:0]     w_act_next;

    assign w_sedge = strobe & ~r_strobe_d;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            spinner_chan #(
                .OUT_W    (OUT_W),
                .STEP_MIN (STEP_MIN),
                .STEP_MAX (STEP_MAX),
                .STEP_INC (STEP_INC),
                .SPIN_SHL (SPIN_SHL),
                .CLAMP    (CLAMP),
                .POS_MIN  (POS_MIN),
                .POS_MAX  (POS_MAX),
                .POS_INIT (POS_INIT)
            ) u_chan (
                .clk     (clk),
                .reset_n (reset_n),
                .i_sedge (w_sedge),
                .i_plus  (plus[gi]),
                .i_minus (minus[gi]),
                .i_spin  (spin_in[gi*SPIN_PKT_W +: SPIN_PKT_W]),
                .o_pos   (pos[gi*OUT_W +: OUT_W]),
                .o_moved (moved[gi]),
                .o_pkt   (w_pkt[gi])
            );
        end
    endgenerate

    // Scan high to low so the lowest-numbered packet channel wins.
    always_comb begin
        w_act_next = r_active_ch;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_pkt[i]) begin
                w_act_next = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_strobe_d  <= 1'b0;
            r_active_ch <= '0;
        end else begin
            r_strobe_d  <= strobe;
            r_active_ch <= w_act_next;
        end
    end

    assign active_ch = r_active_ch;

endmodule
`default_nettype wire

// File: tb/tb_spinner_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_spinner_bank
// Description : Self-checking bench: directed table plus randomized traffic
//               against a behavioural position model, wrap and clamp builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spinner_bank;

`ifdef SPINNER_ACCEL_EN
    localparam bit c_ACCEL = 1'b1;
`else
    localparam bit c_ACCEL = 1'b0;
`endif
    localparam int c_X    = -1;
    localparam int c_KEEP = -9999;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        strobe  = 1'b0;
    logic [2:0]  plus    = '0;
    logic [2:0]  minus   = '0;
    logic [26:0] spin    = '0;

    logic [23:0] pos_w;
    logic [2:0]  moved_w;
    logic [1:0]  act_w;
    logic [15:0] pos_c;
    logic [1:0]  moved_c;
    logic [0:0]  act_c;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    spinner_bank #(
        .CHANNELS(3), .OUT_W(8), .STEP_MIN(1), .STEP_MAX(12), .STEP_INC(1),
        .SPIN_SHL(0), .CLAMP(0), .POS_MIN(0), .POS_MAX(255), .POS_INIT(0)
    ) dut_w (
        .clk(clk), .reset_n(reset_n), .strobe(strobe), .plus(plus), .minus(minus),
        .spin_in(spin), .pos(pos_w), .moved(moved_w), .active_ch(act_w)
    );

    spinner_bank #(
        .CHANNELS(2), .OUT_W(8), .STEP_MIN(1), .STEP_MAX(12), .STEP_INC(1),
        .SPIN_SHL(0), .CLAMP(1), .POS_MIN(37), .POS_MAX(163), .POS_INIT(100)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .strobe(strobe), .plus(2'b00), .minus(2'b00),
        .spin_in(spin[17:0]), .pos(pos_c), .moved(moved_c), .active_ch(act_c)
    );

    // Behavioural model state
    int m_pos_w[3], m_pos_c[2], m_step[3], m_dir[3], m_act_w, m_act_c;
    bit m_mv_w[3], m_mv_c[2], m_tog[3], m_armed, m_sd;

    function automatic int wrap8(input int x);
        return ((x % 256) + 256) % 256;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            m_pos_w[ch] = 0; m_step[ch] = 1; m_dir[ch] = 0; m_mv_w[ch] = 1'b0;
        end
        for (int ch = 0; ch < 2; ch++) begin
            m_pos_c[ch] = 100; m_mv_c[ch] = 1'b0;
        end
        m_act_w = 0; m_act_c = 0; m_armed = 1'b0; m_sd = 1'b0;
    endtask

    task automatic model_edge();
        bit sedge, pkt, got_w, got_c;
        int bd, ad, nv, d, s;
        logic signed [7:0] raw;
        sedge = strobe && !m_sd;
        got_w = 1'b0; got_c = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            bd = 0;
            if (sedge) begin
                if (plus[ch] != minus[ch]) begin
                    d = plus[ch] ? 1 : -1;
                    s = (c_ACCEL && d == m_dir[ch]) ? m_step[ch] : 1;
                    bd = d * s;
                    m_step[ch] = (s + 1 > 12) ? 12 : s + 1;
                    m_dir[ch] = d;
                end else begin
                    m_step[ch] = 1; m_dir[ch] = 0;
                end
            end
            pkt = m_armed && (spin[9*ch+8] != m_tog[ch]);
            m_tog[ch] = spin[9*ch+8];
            raw = spin[9*ch +: 8];
            ad = pkt ? int'(raw) : 0;
            nv = wrap8(m_pos_w[ch] + bd + ad);
            m_mv_w[ch] = (nv != m_pos_w[ch]);
            m_pos_w[ch] = nv;
            if (pkt && !got_w) begin m_act_w = ch; got_w = 1'b1; end
            if (ch < 2) begin
                nv = m_pos_c[ch] + ad;
                nv = (nv < 37) ? 37 : (nv > 163) ? 163 : nv;
                m_mv_c[ch] = (nv != m_pos_c[ch]);
                m_pos_c[ch] = nv;
                if (pkt && !got_c) begin m_act_c = ch; got_c = 1'b1; end
            end
        end
        m_armed = 1'b1;
        m_sd = strobe;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int ch = 0; ch < 3; ch++) begin
            chk($sformatf("pos_w[%0d]", ch), int'(pos_w[8*ch +: 8]), m_pos_w[ch]);
            chk($sformatf("moved_w[%0d]", ch), int'(moved_w[ch]), int'(m_mv_w[ch]));
        end
        for (int ch = 0; ch < 2; ch++) begin
            chk($sformatf("pos_c[%0d]", ch), int'(pos_c[8*ch +: 8]), m_pos_c[ch]);
            chk($sformatf("moved_c[%0d]", ch), int'(moved_c[ch]), int'(m_mv_c[ch]));
        end
        chk("active_w", int'(act_w), m_act_w);
        chk("active_c", int'(act_c), m_act_c);
    endtask

    task automatic apply(input bit rst, input bit [2:0] pl, input bit [2:0] mi,
                         input bit st, input bit [2:0] pk, input int dl);
        reset_n = ~rst; plus = pl; minus = mi; strobe = st;
        for (int ch = 0; ch < 3; ch++) begin
            if (pk[ch]) begin
                spin[9*ch+8] = ~spin[9*ch+8];
                if (dl != c_KEEP) spin[9*ch +: 8] = 8'(dl);
            end
        end
        if (rst) model_reset(); else model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit rst; bit [2:0] pl; bit [2:0] mi; bit st; bit [2:0] pk; int dl;
        int w0a; int w0f; int w1; int c0; int aw; int mw0; int mc0;
    } vec_t;

    vec_t tbl[36];

    initial begin
        tbl[0]  = '{1'b1, 3'd0, 3'd0, 1'b0, 3'd0,  0,   0,   0,   0, 100,   0,   0,   0};
        tbl[1]  = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0,  0,   0,   0,   0, 100,   0,   0,   0};
        tbl[2]  = '{1'b0, 3'd1, 3'd0, 1'b1, 3'd0,  0,   1,   1,   0, c_X, c_X,   1, c_X};
        tbl[3]  = '{1'b0, 3'd1, 3'd0, 1'b0, 3'd0,  0,   1,   1, c_X, c_X, c_X,   0, c_X};
        tbl[4]  = '{1'b0, 3'd1, 3'd0, 1'b1, 3'd0,  0,   3,   2, c_X, c_X, c_X,   1, c_X};
        tbl[5]  = '{1'b0, 3'd1, 3'd0, 1'b0, 3'd0,  0,   3,   2, c_X, c_X, c_X,   0, c_X};
        tbl[6]  = '{1'b0, 3'd1, 3'd0, 1'b1, 3'd0,  0,   6,   3, c_X, c_X, c_X,   1, c_X};
        tbl[7]  = '{1'b0, 3'd1, 3'd0, 1'b0, 3'd0,  0,   6,   3, c_X, c_X, c_X,   0, c_X};
        tbl[8]  = '{1'b0, 3'd1, 3'd0, 1'b1, 3'd0,  0,  10,   4, c_X, c_X, c_X,   1, c_X};
        tbl[9]  = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd2,  5,  10,   4,   5, 100,   1,   0,   0};
        tbl[10] = '{1'b1, 3'd0, 3'd0, 1'b0, 3'd0,  0,   0,   0,   0, 100,   0,   0,   0};
        tbl[11] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0,  0,   0,   0,   0, 100,   0,   0,   0};
        tbl[12] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd1, -6, 250, 250,   0,  94,   0,   1,   1};
        tbl[13] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd1, 10,   4,   4,   0, 104,   0,   1,   1};
        tbl[14] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0,  0,   4,   4,   0, 104,   0,   0,   0};
        tbl[15] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd1, 56,  60,  60,   0, 160,   0,   1,   1};
        tbl[16] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd1, 10,  70,  70,   0, 163,   0,   1,   1};
        tbl[17] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd1,  5,  75,  75,   0, 163,   0,   1,   0};
        tbl[18] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd2, 50,  75,  75,  50, 163,   1,   0,   0};
        tbl[19] = '{1'b0, 3'd2, 3'd0, 1'b1, 3'd2, -3,  75,  75,  48, 163,   1,   0,   0};
        tbl[20] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0,  0,  75,  75,  48, 163,   1,   0,   0};
        tbl[21] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd4,  1,  75,  75,  48, 163,   2,   0,   0};
        tbl[22] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd5,  1,  76,  76,  48, 163,   0,   1,   0};
        tbl[23] = '{1'b0, 3'd1, 3'd0, 1'b1, 3'd0,  0,  77,  77, c_X, c_X, c_X,   1, c_X};
        tbl[24] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0,  0,  77,  77, c_X, c_X, c_X,   0, c_X};
        tbl[25] = '{1'b0, 3'd1, 3'd0, 1'b1, 3'd0,  0,  79,  78, c_X, c_X, c_X,   1, c_X};
        tbl[26] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0,  0,  79,  78, c_X, c_X, c_X,   0, c_X};
        tbl[27] = '{1'b0, 3'd1, 3'd1, 1'b1, 3'd0,  0,  79,  78, c_X, c_X, c_X,   0, c_X};
        tbl[28] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0,  0,  79,  78, c_X, c_X, c_X,   0, c_X};
        tbl[29] = '{1'b0, 3'd1, 3'd0, 1'b1, 3'd0,  0,  80,  79, c_X, c_X, c_X,   1, c_X};
        tbl[30] = '{1'b0, 3'd1, 3'd0, 1'b1, 3'd0,  0,  80,  79, c_X, c_X, c_X,   0, c_X};
        tbl[31] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0,  0,  80,  79, c_X, c_X, c_X,   0, c_X};
        tbl[32] = '{1'b0, 3'd0, 3'd1, 1'b1, 3'd0,  0,  79,  78, c_X, c_X, c_X,   1, c_X};
        tbl[33] = '{1'b0, 3'd0, 3'd1, 1'b0, 3'd0,  0,  79,  78, c_X, c_X, c_X,   0, c_X};
        tbl[34] = '{1'b0, 3'd0, 3'd1, 1'b1, 3'd0,  0,  77,  77, c_X, c_X, c_X,   1, c_X};
        tbl[35] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0,  0,  77,  77, c_X, c_X, c_X,   0, c_X};

        // Toggle bits already high while reset releases: must not count as packets.
        spin[8]  = 1'b1;
        spin[17] = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        for (int r = 0; r < 36; r++) begin
            apply(tbl[r].rst, tbl[r].pl, tbl[r].mi, tbl[r].st, tbl[r].pk, tbl[r].dl);
            if (tbl[r].w0a >= 0)
                chk($sformatf("tbl%0d_pos_w0", r), int'(pos_w[7:0]), c_ACCEL ? tbl[r].w0a : tbl[r].w0f);
            if (tbl[r].w1 >= 0)
                chk($sformatf("tbl%0d_pos_w1", r), int'(pos_w[15:8]), tbl[r].w1);
            if (tbl[r].c0 >= 0)
                chk($sformatf("tbl%0d_pos_c0", r), int'(pos_c[7:0]), tbl[r].c0);
            if (tbl[r].aw >= 0)
                chk($sformatf("tbl%0d_active_w", r), int'(act_w), tbl[r].aw);
            if (tbl[r].mw0 >= 0)
                chk($sformatf("tbl%0d_moved_w0", r), int'(moved_w[0]), tbl[r].mw0);
            if (tbl[r].mc0 >= 0)
                chk($sformatf("tbl%0d_moved_c0", r), int'(moved_c[0]), tbl[r].mc0);
        end

        for (int n = 0; n < 400; n++) begin
            for (int ch = 0; ch < 3; ch++) spin[9*ch +: 8] = 8'($urandom);
            apply($urandom_range(0, 99) == 0, 3'($urandom), 3'($urandom),
                  1'($urandom), 3'($urandom), c_KEEP);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
